perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised bank of event counters for pipeline and cache performance monitoring. It generalises the single-channel 16-bit stall counter to NUM_CNT channels of configurable width. Each channel has selectable level or edge counting, a wrap or saturate mode, sticky overflow, and selective clear. An atomic snapshot shadow bank lets software read a consistent set of counts through one registered read port. The block sits beside the hazard detection unit; its event inputs are stall, bubble, flush, and cache-miss strobes.

Parameters:
NUM_CNT, 8, number of counter channels (1..32)
CNT_WIDTH, 16, bits per counter (2..32)
SATURATE, 0, 0 = counters wrap to 0 past max; 1 = counters hold at max
SEL_WIDTH, $clog2(NUM_CNT) (minimum 1), width of index/select ports; derived, not overridden

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
event_in  in  NUM_CNT  per-channel event strobe
edge_mode  in  NUM_CNT  per-channel mode: 1 = count rising edges of event_in, 0 = count cycles event_in is high
count_en  in  1  global count enable
freeze  in  1  suspends all increments; state is held
clear_all  in  1  zeroes all counters and overflow flags
clear_valid  in  1  qualifies clear_idx
clear_idx  in  SEL_WIDTH  channel to zero when clear_valid is high
snap  in  1  copies all live counters and overflow flags into the shadow bank
rd_sel  in  SEL_WIDTH  channel to read
rd_shadow  in  1  1 = read the shadow bank, 0 = read live counters
rd_data  out  CNT_WIDTH  registered read data
rd_ovf  out  1  registered overflow flag of the selected channel
ovf_any  out  1  OR of all live overflow flags (registered state, no extra latency)

Behaviour:
- Reset (synchronous, high during a rising edge) forces the following to 0: all live counters, shadow counters, live and shadow ovf flags, the edge history register prev[], rd_data, rd_ovf, and ovf_any. Reset overrides every other input.
- Qualified event for channel i:
  - level mode: event_in[i]
  - edge mode: event_in[i] & ~prev[i]
- prev[i] <= event_in[i] every cycle that is not a reset cycle, regardless of freeze or count_en. Edge detection therefore stays continuous. After reset prev = 0, so an input that is already high counts as one edge.
- Increment: counter i increments when count_en & ~freeze & qualified[i]. There is at most +1 per cycle per channel. Channels are independent.
- At all-ones, an increment does one of the following:
  - SATURATE = 0: the counter goes to 0 and ovf[i] <= 1.
  - SATURATE = 1: the counter stays at all-ones and ovf[i] <= 1.
  - ovf is sticky until it is cleared or reset.
- Priority for channel i, highest first: reset > clear_all > (clear_valid & clear_idx == i) > increment. A cleared channel is 0 next cycle even if an event occurred that cycle, and its ovf flag clears too. clear_idx >= NUM_CNT is ignored.
- Snap: shadow[i] <= the live counter value before this edge's update, for all i in the same cycle. Shadow ovf flags are copied the same way. Snap is not affected by freeze.
  - If snap and clear occur together, the shadow captures the pre-clear value.
- Read: 1-cycle latency. At each edge:
  - rd_data <= (rd_shadow ? shadow[rd_sel] : live[rd_sel]) using pre-update values.
  - rd_ovf <= the matching ovf flag.
  - rd_sel >= NUM_CNT returns rd_data = 0 and rd_ovf = 0.
- ovf_any is combinational OR of the live ovf registers. It is 1 the cycle after the first overflow and 0 the cycle after clear_all.
- freeze = 1 or count_en = 0 holds counters. Clears, snap, and reads still operate.
- Reset asserted mid-count discards all state. The first countable cycle is the one after reset deasserts.

Test Plan:
- Level count, ch0: reset, count_en = 1, event_in[0] high for 5 cycles, then rd_sel = 0 -> rd_data = 5 one cycle later; all other channels read 0.
- Edge mode, ch1: edge_mode[1] = 1, event_in[1] high for 4 cycles, low 2, high 3 -> count = 2. Same stimulus with edge_mode[1] = 0 -> 7.
- Wrap vs saturate, CNT_WIDTH = 4, 17 level events on ch2:
  - SATURATE = 0 -> count = 1, rd_ovf = 1, ovf_any = 1.
  - SATURATE = 1 -> count = 15, rd_ovf = 1.
- Clear priority: ch3 at 9, then clear_valid = 1, clear_idx = 3, and event_in[3] = 1 in the same cycle -> ch3 = 0 next cycle. ch4 at 6, same cycle, is unchanged at 6 (+event if present). clear_idx = 9 with NUM_CNT = 8 -> no change.
- Snapshot: ch0 = 10, pulse snap while event_in[0] = 1, keep counting 3 more cycles -> rd_shadow = 1 returns 10, rd_shadow = 0 returns 14. A following clear_all leaves the shadow at 10.
- Freeze/reset: freeze = 1 for 4 event cycles -> counts unchanged. Then reset for 1 cycle mid-stream -> all counts, flags, and rd_data = 0; edge-mode channel with input held high counts 1 after reset deasserts.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters with level/edge qualification, wrap or saturate,
// sticky overflow, selective clear and an atomic snapshot shadow bank behind one read port.
module perf_counter_bank #(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 16,
  parameter bit SATURATE  = 1'b0,
  parameter int SEL_WIDTH = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CNT-1:0]   event_in,
  input  logic [NUM_CNT-1:0]   edge_mode,
  input  logic                 count_en,
  input  logic                 freeze,
  input  logic                 clear_all,
  input  logic                 clear_valid,
  input  logic [SEL_WIDTH-1:0] clear_idx,
  input  logic                 snap,
  input  logic [SEL_WIDTH-1:0] rd_sel,
  input  logic                 rd_shadow,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_ovf,
  output logic                 ovf_any
);

  logic [CNT_WIDTH-1:0] live   [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf;
  logic [NUM_CNT-1:0]   shadow_ovf;
  logic [NUM_CNT-1:0]   prev;
  logic [NUM_CNT-1:0]   qual;
  logic [NUM_CNT-1:0]   inc;
  logic [NUM_CNT-1:0]   clr;
  logic [CNT_WIDTH-1:0] rd_data_next;
  logic                 rd_ovf_next;

  // Edge-mode channels only see the cycle where the input rises.
  always_comb begin
    qual = event_in & ~(edge_mode & prev);
    inc  = (count_en && !freeze) ? qual : '0;
    clr  = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      clr[i] = clear_all || (clear_valid && (clear_idx == SEL_WIDTH'(i)));
    end
  end

  // Select by comparison so an out-of-range rd_sel falls through to zero.
  always_comb begin
    rd_data_next = '0;
    rd_ovf_next  = 1'b0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_WIDTH'(i)) begin
        rd_data_next = rd_shadow ? shadow[i] : live[i];
        rd_ovf_next  = rd_shadow ? shadow_ovf[i] : ovf[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      ovf        <= '0;
      shadow_ovf <= '0;
      prev       <= '0;
      rd_data    <= '0;
      rd_ovf     <= 1'b0;
    end else begin
      prev    <= event_in;
      rd_data <= rd_data_next;
      rd_ovf  <= rd_ovf_next;
      if (snap) begin
        shadow     <= live;
        shadow_ovf <= ovf;
      end
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (clr[i]) begin
          live[i] <= '0;
          ovf[i]  <= 1'b0;
        end else if (inc[i]) begin
          if (&live[i]) begin
            live[i] <= SATURATE ? live[i] : '0;
            ovf[i]  <= 1'b1;
          end else begin
            live[i] <= live[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign ovf_any = |ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default-width bank plus 4-bit wrap and saturate
// banks of 5 channels, which also exercise out-of-range clear/read indices.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] event_in = '0;
  logic [7:0] edge_mode = '0;
  logic       count_en = 1'b1;
  logic       freeze = 1'b0;
  logic       clear_all = 1'b0;
  logic       clear_valid = 1'b0;
  logic [2:0] clear_idx = '0;
  logic       snap = 1'b0;
  logic [2:0] rd_sel = '0;
  logic       rd_shadow = 1'b0;

  logic [15:0] m_rd_data;
  logic        m_rd_ovf, m_ovf_any;
  logic [3:0]  w_rd_data;
  logic        w_rd_ovf, w_ovf_any;
  logic [3:0]  s_rd_data;
  logic        s_rd_ovf, s_ovf_any;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter_bank u_main (
    .clk(clk), .reset(reset), .event_in(event_in), .edge_mode(edge_mode),
    .count_en(count_en), .freeze(freeze), .clear_all(clear_all),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(m_rd_data), .rd_ovf(m_rd_ovf), .ovf_any(m_ovf_any)
  );

  perf_counter_bank #(.NUM_CNT(5), .CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .event_in(event_in[4:0]), .edge_mode(edge_mode[4:0]),
    .count_en(count_en), .freeze(freeze), .clear_all(clear_all),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(w_rd_data), .rd_ovf(w_rd_ovf), .ovf_any(w_ovf_any)
  );

  perf_counter_bank #(.NUM_CNT(5), .CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .event_in(event_in[4:0]), .edge_mode(edge_mode[4:0]),
    .count_en(count_en), .freeze(freeze), .clear_all(clear_all),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .snap(snap),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(s_rd_data), .rd_ovf(s_rd_ovf), .ovf_any(s_ovf_any)
  );

  typedef struct {
    string       name;
    logic [2:0]  ch;
    logic        edge_m;
    logic [31:0] pattern;
    int          ncyc;
    int          exp_main;
    int          exp_wrap;
    int          exp_sat;
    logic        exp_ovf;
  } vec_t;

  vec_t v [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    v[0] = '{"lvl_ch0_5",      3'd0, 1'b0, 32'h0000_001F,  5,  5,  5,  5, 1'b0};
    v[1] = '{"edge_ch1_4_2_3", 3'd1, 1'b1, 32'h0000_01CF,  9,  2,  2,  2, 1'b0};
    v[2] = '{"lvl_ch1_4_2_3",  3'd1, 1'b0, 32'h0000_01CF,  9,  7,  7,  7, 1'b0};
    v[3] = '{"lvl_ch2_17",     3'd2, 1'b0, 32'h0001_FFFF, 17, 17,  1, 15, 1'b1};
    v[4] = '{"edge_ch3_alt",   3'd3, 1'b1, 32'h0000_0055,  7,  4,  4,  4, 1'b0};
    v[5] = '{"lvl_ch4_16",     3'd4, 1'b0, 32'h0000_FFFF, 16, 16,  0, 15, 1'b1};
    v[6] = '{"lvl_ch4_15",     3'd4, 1'b0, 32'h0000_7FFF, 15, 15, 15, 15, 1'b0};
    v[7] = '{"lvl_ch7_oob",    3'd7, 1'b0, 32'h0000_0007,  3,  3,  0,  0, 1'b0};
    v[8] = '{"edge_ch0_held",  3'd0, 1'b1, 32'h0000_0007,  3,  1,  1,  1, 1'b0};

    tick();
    tick();
    reset = 1'b0;
    chk("reset_rd_data", 32'(m_rd_data), 0);
    chk("reset_rd_ovf", 32'(m_rd_ovf), 0);
    chk("reset_ovf_any", 32'(m_ovf_any), 0);

    for (int r = 0; r < 9; r++) begin
      edge_mode = '0;
      edge_mode[v[r].ch] = v[r].edge_m;
      do_reset();
      for (int k = 0; k < v[r].ncyc; k++) begin
        event_in = '0;
        event_in[v[r].ch] = v[r].pattern[k];
        tick();
      end
      event_in = '0;
      rd_sel = v[r].ch;
      rd_shadow = 1'b0;
      tick();
      chk({v[r].name, "_main"}, 32'(m_rd_data), v[r].exp_main);
      chk({v[r].name, "_main_ovf"}, 32'(m_ovf_any), 0);
      chk({v[r].name, "_wrap"}, 32'(w_rd_data), v[r].exp_wrap);
      chk({v[r].name, "_wrap_ovf"}, 32'(w_rd_ovf), 32'(v[r].exp_ovf));
      chk({v[r].name, "_sat"}, 32'(s_rd_data), v[r].exp_sat);
      chk({v[r].name, "_sat_ovf"}, 32'(s_rd_ovf), 32'(v[r].exp_ovf));
      rd_sel = v[r].ch + 3'd1;
      tick();
      chk({v[r].name, "_other_main"}, 32'(m_rd_data), 0);
      chk({v[r].name, "_other_wrap"}, 32'(w_rd_data), 0);
    end

    // Clear priority: ch3 at 9, ch4 at 6, clear ch3 while both see an event.
    edge_mode = '0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      event_in = '0;
      event_in[3] = 1'b1;
      event_in[4] = (k < 6);
      tick();
    end
    event_in[3] = 1'b1;
    event_in[4] = 1'b1;
    clear_valid = 1'b1;
    clear_idx = 3'd3;
    tick();
    clear_valid = 1'b0;
    event_in = '0;
    rd_sel = 3'd3;
    tick();
    chk("clr_ch3_main", 32'(m_rd_data), 0);
    chk("clr_ch3_wrap", 32'(w_rd_data), 0);
    rd_sel = 3'd4;
    tick();
    chk("clr_ch4_main", 32'(m_rd_data), 7);
    chk("clr_ch4_wrap", 32'(w_rd_data), 7);
    clear_valid = 1'b1;
    clear_idx = 3'd6;
    tick();
    clear_valid = 1'b0;
    tick();
    chk("clr_oob_wrap", 32'(w_rd_data), 7);
    chk("clr_oob_main", 32'(m_rd_data), 7);

    // Snapshot mid-count, then clear_all must leave the shadow alone.
    do_reset();
    event_in[0] = 1'b1;
    repeat (10) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    repeat (3) tick();
    event_in = '0;
    rd_sel = 3'd0;
    rd_shadow = 1'b1;
    tick();
    chk("snap_shadow", 32'(m_rd_data), 10);
    rd_shadow = 1'b0;
    tick();
    chk("snap_live", 32'(m_rd_data), 14);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    rd_shadow = 1'b1;
    tick();
    chk("snap_after_clr", 32'(m_rd_data), 10);
    rd_shadow = 1'b0;
    tick();
    chk("live_after_clr", 32'(m_rd_data), 0);

    // Freeze and count_en hold the counters.
    do_reset();
    event_in[0] = 1'b1;
    repeat (3) tick();
    freeze = 1'b1;
    repeat (4) tick();
    freeze = 1'b0;
    count_en = 1'b0;
    repeat (2) tick();
    count_en = 1'b1;
    event_in = '0;
    rd_sel = 3'd0;
    tick();
    chk("freeze_hold", 32'(m_rd_data), 3);

    // Overflow flags: selective clear, clear_all, then reset mid-stream.
    do_reset();
    event_in[2] = 1'b1;
    repeat (16) tick();
    chk("ovf_any_wrap", 32'(w_ovf_any), 1);
    chk("ovf_any_sat", 32'(s_ovf_any), 1);
    chk("ovf_any_main", 32'(m_ovf_any), 0);
    event_in = '0;
    clear_valid = 1'b1;
    clear_idx = 3'd2;
    tick();
    clear_valid = 1'b0;
    chk("ovf_idxclr_wrap", 32'(w_ovf_any), 0);
    chk("ovf_idxclr_sat", 32'(s_ovf_any), 0);
    event_in[2] = 1'b1;
    repeat (16) tick();
    chk("ovf_again_wrap", 32'(w_ovf_any), 1);
    event_in = '0;
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    chk("ovf_clrall_wrap", 32'(w_ovf_any), 0);
    event_in[2] = 1'b1;
    repeat (17) tick();
    rd_sel = 3'd2;
    tick();
    chk("pre_rst_main", 32'(m_rd_data), 17);
    chk("pre_rst_wrap", 32'(w_rd_data), 1);
    chk("pre_rst_wrap_ovf", 32'(w_rd_ovf), 1);
    reset = 1'b1;
    edge_mode[1] = 1'b1;
    event_in[1] = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rd_data_main", 32'(m_rd_data), 0);
    chk("rst_rd_data_wrap", 32'(w_rd_data), 0);
    chk("rst_rd_ovf_wrap", 32'(w_rd_ovf), 0);
    chk("rst_ovf_any_wrap", 32'(w_ovf_any), 0);
    event_in[2] = 1'b0;
    repeat (3) tick();
    event_in = '0;
    rd_sel = 3'd1;
    tick();
    chk("rst_edge_main", 32'(m_rd_data), 1);
    chk("rst_edge_wrap", 32'(w_rd_data), 1);
    rd_sel = 3'd2;
    tick();
    chk("rst_ch2_main", 32'(m_rd_data), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
